sha3_absorb_ctrl: RTL
=====================

// Module: sha3_absorb_ctrl
// PURPOSE
//  Sequences one SHA3-512 hash of a message in OCM. Schedules burst reads (read_addr_index/init_master_txn),
//  drains 64-bit words from the bus FIFO, and drives the keccak absorb interface (in_ready/is_last/byte_num).
//  Captures the 512-bit digest. Sits between the burst master + Bus_FIFO and the keccak core.
// PARAMETERS
//  BURST_BYTES  64  bytes delivered per burst (power of 2, multiple of 8)
//  LEN_W        32  width of msg_len_bytes
// PORTS
//  clk              in   1    system clock
//  reset_n          in   1    asynchronous active-low reset
//  start            in   1    1-cycle pulse: begin hash; ignored while busy
//  msg_len_bytes    in   LEN_W message length in bytes, sampled on accepted start
//  busy             out  1    high from accepted start until done
//  done             out  1    1-cycle pulse when hash_out valid
//  hash_out         out  512  digest, held until next accepted start
//  init_master_txn  out  1    1-cycle pulse: launch burst at read_addr_index
//  read_addr_index  out  32   burst index, 0-based per message
//  read_done        in   1    burst complete
//  fifo_half_full   in   1    throttle: no new burst while high
//  fifo_empty       in   1    bus FIFO empty
//  fifo_read_en     out  1    pop one 64-bit word
//  fifo_read_data   in   64   word, valid the cycle after fifo_read_en sampled high
//  keccak_input     out  64   absorb word
//  in_ready         out  1    absorb strobe
//  is_last          out  1    final absorb cycle
//  byte_num         out  3    valid bytes in final word (0..7)
//  buffer_full      in   1    keccak busy: in_ready must stay low
//  out_ready        in   1    keccak digest valid
//  keccak_out       in   512  keccak digest
// BEHAVIOUR
//  Reset (async, any time incl. mid-hash): all outputs 0, hash_out=0, both FSMs IDLE, counters 0.
//  On accepted start latch: full_words=len>>3, rem=len[2:0], bursts=ceil(len/BURST_BYTES),
//   total_words=bursts*BURST_BYTES/8. len=0 -> bursts=0.
//  Burst scheduler FSM: S_IDLE -> S_REQ when issued<bursts && !fifo_half_full; S_REQ pulses
//   init_master_txn with read_addr_index=issued -> S_WAIT; read_done -> issued++, S_IDLE.
//   One burst outstanding max. Stops when issued==bursts.
//  Absorb FSM: IDLE -> POP (fifo_empty low: fifo_read_en=1, 1 cycle) -> CAP (register word) ->
//   FEED (wait !buffer_full, then in_ready=1 one cycle) -> POP ... .
//   Words 0..full_words-1: is_last=0. Word full_words when rem!=0: is_last=1, byte_num=rem.
//   rem==0 (incl. len=0): after last full word, one extra cycle in_ready=1,is_last=1,byte_num=0,
//   keccak_input=0, no FIFO pop.
//   in_ready never high while buffer_full high; in_ready high exactly one cycle per word.
//  DRAIN: after final absorb, pop and discard words until popped==total_words (burst padding).
//  WAIT_HASH: on out_ready, hash_out<=keccak_out; DONE: done=1 one cycle, busy=0 -> IDLE.
//  fifo_read_en never asserted while fifo_empty high or when popped==total_words.
//  start while busy: ignored, no state change. out_ready before final absorb: ignored.
//  Counters LEN_W wide; no wrap within one message (len < 2^LEN_W - BURST_BYTES).
// STRUCTURE
//  Shared header sha3_defs.vh: absorb/burst state encodings, WORD_BYTES=8, HASH_W=512.
//  One sub-module: sha3_burst_sched (burst scheduler FSM + issued counter).
// TESTING
//  len=64: 1 burst (idx 0), 8 words is_last=0, then is_last=1/byte_num=0 -> hash_out=keccak_out, done 1 cycle.
//  len=13: 1 burst, word0 is_last=0, word1 is_last=1 byte_num=5, 6 words drained, done.
//  len=0: no init_master_txn, single is_last=1 byte_num=0 cycle, done.
//  len=200, buffer_full held high 10 cycles mid-stream: in_ready stays low, no word lost, 4 bursts idx 0..3.
//  fifo_half_full high: init_master_txn withheld until low; start pulse while busy ignored.
//  reset_n low mid-FEED: all outputs 0 immediately; new start len=8 then completes normally.

Source files
------------

// File: rtl/sha3_absorb_ctrl_pkg.sv
// ============================================================================
//  Module : sha3_absorb_ctrl_pkg
//  Brief  : Shared constants and state encodings for the SHA3 absorb control.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package sha3_absorb_ctrl_pkg;

  localparam int WORD_BYTES = 8;
  localparam int WORD_W     = 64;
  localparam int HASH_W     = 512;

  typedef enum logic [2:0] {
    A_IDLE      = 3'd0,
    A_POP       = 3'd1,
    A_CAP       = 3'd2,
    A_FEED      = 3'd3,
    A_PAD       = 3'd4,
    A_DRAIN     = 3'd5,
    A_WAIT_HASH = 3'd6,
    A_DONE      = 3'd7
  } absorb_state_t;

  typedef enum logic [1:0] {
    B_IDLE = 2'd0,
    B_REQ  = 2'd1,
    B_WAIT = 2'd2
  } burst_state_t;

endpackage

`default_nettype wire

// File: rtl/sha3_burst_sched.sv
// ============================================================================
//  Module : sha3_burst_sched
//  Brief  : Issues one burst read at a time until the message's bursts are out.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sha3_burst_sched
  import sha3_absorb_ctrl_pkg::*;
#(
  parameter int LEN_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic [LEN_W-1:0] bursts,
  input  logic             fifo_half_full,
  input  logic             read_done,
  output logic             init_master_txn,
  output logic [31:0]      read_addr_index
);

  burst_state_t     r_state;
  burst_state_t     w_state_nxt;
  logic [LEN_W-1:0] r_issued;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= B_IDLE;
      r_issued <= '0;
    end else if (clear) begin
      r_state  <= B_IDLE;
      r_issued <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == B_WAIT && read_done)
        r_issued <= r_issued + LEN_W'(1);
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    init_master_txn = 1'b0;
    case (r_state)
      B_IDLE:  if (r_issued < bursts && !fifo_half_full) w_state_nxt = B_REQ;
      B_REQ: begin
        init_master_txn = 1'b1;
        w_state_nxt     = B_WAIT;
      end
      B_WAIT:  if (read_done) w_state_nxt = B_IDLE;
      default: w_state_nxt = B_IDLE;
    endcase
  end

  assign read_addr_index = 32'(r_issued);

endmodule

`default_nettype wire

// File: rtl/sha3_absorb_ctrl.sv
// ============================================================================
//  Module : sha3_absorb_ctrl
//  Brief  : Sequences one SHA3-512 hash: burst reads, FIFO drain, keccak absorb.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sha3_absorb_ctrl
  import sha3_absorb_ctrl_pkg::*;
#(
  parameter int BURST_BYTES = 64,
  parameter int LEN_W       = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  msg_len_bytes,
  output logic              busy,
  output logic              done,
  output logic [HASH_W-1:0] hash_out,
  output logic              init_master_txn,
  output logic [31:0]       read_addr_index,
  input  logic              read_done,
  input  logic              fifo_half_full,
  input  logic              fifo_empty,
  output logic              fifo_read_en,
  input  logic [WORD_W-1:0] fifo_read_data,
  output logic [WORD_W-1:0] keccak_input,
  output logic              in_ready,
  output logic              is_last,
  output logic [2:0]        byte_num,
  input  logic              buffer_full,
  input  logic              out_ready,
  input  logic [HASH_W-1:0] keccak_out
);

  localparam int BURST_SHIFT = $clog2(BURST_BYTES);
  localparam int WPB_SHIFT   = $clog2(BURST_BYTES / WORD_BYTES);
  localparam int WB_SHIFT    = $clog2(WORD_BYTES);

  absorb_state_t     r_state;
  absorb_state_t     w_state_nxt;
  logic [LEN_W-1:0]  r_full_words;
  logic [LEN_W-1:0]  r_total_words;
  logic [LEN_W-1:0]  r_bursts;
  logic [LEN_W-1:0]  r_popped;
  logic [LEN_W-1:0]  r_absorbed;
  logic [2:0]        r_rem;
  logic [WORD_W-1:0] r_word;
  logic [HASH_W-1:0] r_hash;

  logic              w_idle;
  logic              w_accept;
  logic [LEN_W:0]    w_len_round;
  logic [LEN_W-1:0]  w_bursts;
  logic              w_word_last;
  logic              w_more_words;

  assign w_idle      = (r_state == A_IDLE) || (r_state == A_DONE);
  assign w_accept    = start && w_idle;
  assign w_len_round = {1'b0, msg_len_bytes} + (LEN_W+1)'(BURST_BYTES - 1);
  assign w_bursts    = LEN_W'(w_len_round >> BURST_SHIFT);

  // Only the trailing partial word sits at index full_words.
  assign w_word_last  = (r_absorbed == r_full_words);
  assign w_more_words = ((r_absorbed + LEN_W'(1)) < r_full_words) || (r_rem != 3'd0);

  assign busy     = !w_idle;
  assign hash_out = r_hash;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= A_IDLE;
      r_full_words  <= '0;
      r_total_words <= '0;
      r_bursts      <= '0;
      r_popped      <= '0;
      r_absorbed    <= '0;
      r_rem         <= '0;
      r_word        <= '0;
      r_hash        <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_full_words  <= msg_len_bytes >> WB_SHIFT;
        r_rem         <= msg_len_bytes[2:0];
        r_bursts      <= w_bursts;
        r_total_words <= w_bursts << WPB_SHIFT;
        r_popped      <= '0;
        r_absorbed    <= '0;
      end else begin
        if (fifo_read_en) r_popped   <= r_popped + LEN_W'(1);
        if (in_ready)     r_absorbed <= r_absorbed + LEN_W'(1);
      end
      if (r_state == A_CAP) r_word <= fifo_read_data;
      if (r_state == A_WAIT_HASH && out_ready) r_hash <= keccak_out;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    fifo_read_en = 1'b0;
    in_ready     = 1'b0;
    is_last      = 1'b0;
    byte_num     = 3'd0;
    keccak_input = '0;
    done         = 1'b0;
    case (r_state)
      A_IDLE, A_DONE: begin
        done        = (r_state == A_DONE);
        w_state_nxt = A_IDLE;
        if (start) w_state_nxt = (msg_len_bytes != '0) ? A_POP : A_PAD;
      end
      A_POP: begin
        if (!fifo_empty && r_popped != r_total_words) begin
          fifo_read_en = 1'b1;
          w_state_nxt  = A_CAP;
        end
      end
      A_CAP: w_state_nxt = A_FEED;
      A_FEED: begin
        keccak_input = r_word;
        if (!buffer_full) begin
          in_ready    = 1'b1;
          is_last     = w_word_last;
          byte_num    = w_word_last ? r_rem : 3'd0;
          w_state_nxt = w_word_last ? A_DRAIN : (w_more_words ? A_POP : A_PAD);
        end
      end
      // Empty final block for word-aligned messages: no data behind it.
      A_PAD: begin
        if (!buffer_full) begin
          in_ready    = 1'b1;
          is_last     = 1'b1;
          w_state_nxt = A_DRAIN;
        end
      end
      A_DRAIN: begin
        if (r_popped == r_total_words) w_state_nxt = A_WAIT_HASH;
        else if (!fifo_empty)          fifo_read_en = 1'b1;
      end
      A_WAIT_HASH: if (out_ready) w_state_nxt = A_DONE;
      default: w_state_nxt = A_IDLE;
    endcase
  end

  sha3_burst_sched #(
    .LEN_W(LEN_W)
  ) u_burst_sched (
    .clk            (clk),
    .reset_n        (reset_n),
    .clear          (w_accept),
    .bursts         (r_bursts),
    .fifo_half_full (fifo_half_full),
    .read_done      (read_done),
    .init_master_txn(init_master_txn),
    .read_addr_index(read_addr_index)
  );

endmodule

`default_nettype wire
